// File: rtl/input_fetch_ctrl.sv
// Input-buffer fetch controller: streams `length` words from base_addr onward
// into a 2-entry FIFO and presents them on a valid/ready/last interface.
module input_fetch_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_rd_en,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  input  logic                  buf_rd_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_rd_cnt;
  logic [LEN_WIDTH-1:0]  r_out_cnt;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  r_inflight;

  logic       w_busy;
  logic       w_not_empty;
  logic       w_pop;
  logic       w_push;
  logic [2:0] w_occ;
  logic       w_issue;
  logic       w_last_rd;
  logic       w_last_out;

  assign w_busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_not_empty = (r_count != 2'd0);
  assign w_pop       = w_not_empty && out_ready;
  assign w_push      = buf_rd_valid && w_busy;
  // Buffered + in-flight words after this cycle's pop; a read needs a free slot.
  assign w_occ       = ({1'b0, r_count} + {2'b00, r_inflight}) - {2'b00, w_pop};
  assign w_issue     = (r_state == S_FETCH) && (w_occ < 3'd2);
  assign w_last_rd   = (r_rd_cnt == (r_len - LEN_WIDTH'(1)));
  assign w_last_out  = (r_out_cnt == (r_len - LEN_WIDTH'(1)));

  assign busy        = w_busy;
  assign done        = (r_state == S_DONE);
  assign buf_rd_en   = w_issue;
  assign buf_rd_addr = r_addr;
  assign out_valid   = w_not_empty;
  assign out_data    = w_not_empty ? r_mem[r_rd_ptr] : {DATA_WIDTH{1'b0}};
  assign out_last    = w_not_empty && w_last_out;

  // Control FSM, read address and read counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_addr   <= {ADDR_WIDTH{1'b0}};
      r_len    <= {LEN_WIDTH{1'b0}};
      r_rd_cnt <= {LEN_WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len    <= length;
            r_addr   <= base_addr;
            r_rd_cnt <= {LEN_WIDTH{1'b0}};
            r_state  <= (length == {LEN_WIDTH{1'b0}}) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            r_addr   <= r_addr + ADDR_WIDTH'(1);
            r_rd_cnt <= r_rd_cnt + LEN_WIDTH'(1);
            if (w_last_rd) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && w_last_out) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output word counter, cleared when a new transfer is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_cnt <= {LEN_WIDTH{1'b0}};
    end else if ((r_state == S_IDLE) && start) begin
      r_out_cnt <= {LEN_WIDTH{1'b0}};
    end else if (w_pop) begin
      r_out_cnt <= r_out_cnt + LEN_WIDTH'(1);
    end
  end

  // FIFO pointers, occupancy and the single outstanding-read flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= buf_rd_data;
    end
  end

endmodule

// File: doc/input_fetch_ctrl.md
INPUT_FETCH_CTRL -- requirements
Module: input_fetch_ctrl

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, the activation word width (Q8.8).
REQ-002 SHALL provide parameter ADDR_WIDTH, default 8, the input-buffer address width.
REQ-003 SHALL provide parameter LEN_WIDTH, default 9, the transfer-length width, so lengths 0..256 are representable.
REQ-004 SHALL use one clock; reset is synchronous and active-low; ports are named clk and rst_n.
REQ-005 SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a fetch.
- base_addr  in  ADDR_WIDTH  first buffer address; sampled with start.
- length  in  LEN_WIDTH  number of words to fetch; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; transfer complete.
- buf_rd_en  out  1  read strobe to the input buffer.
- buf_rd_addr  out  ADDR_WIDTH  read address to the input buffer.
- buf_rd_data  in  DATA_WIDTH  word returned by the buffer.
- buf_rd_valid  in  1  buf_rd_data is valid this cycle; arrives 1 cycle after buf_rd_en.
- out_data  out  DATA_WIDTH  word to the matrix-multiply unit.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the word.
- out_last  out  1  qualifies the final word of the transfer.

Function
REQ-006 SHALL implement the FSM states IDLE, FETCH, DRAIN and DONE.
REQ-007 IDLE: start=1 SHALL latch base_addr and length. If length≠0, the next state is FETCH. If length=0, the next state is DONE and no read is issued.
REQ-008 start SHALL be ignored in every state other than IDLE.
REQ-009 FETCH: the block SHALL assert buf_rd_en for one cycle per word, addresses base_addr, base_addr+1, …, with the address incremented modulo 2^ADDR_WIDTH (0xFF wraps to 0x00).
REQ-010 The first buf_rd_en SHALL occur in the cycle immediately after start is accepted.
REQ-011 The block SHALL hold an internal 2-entry FIFO for returned words. It SHALL write buf_rd_data into the FIFO in any cycle where buf_rd_valid=1 and busy=1.
REQ-012 Credit rule: a read SHALL be issued only if (FIFO occupancy + reads in flight − pop this cycle) < 2. The FIFO SHALL never overflow, and returned data SHALL never be dropped.
REQ-013 When the last read has been issued, the FSM SHALL move from FETCH to DRAIN.
REQ-014 When the final word handshake occurs, the FSM SHALL move from DRAIN to DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 out_valid SHALL equal FIFO-not-empty, and out_data SHALL be the FIFO head.
REQ-017 A pop SHALL occur only when out_valid=1 and out_ready=1.
REQ-018 out_data and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-019 out_last SHALL be 1 only while out_valid=1 and the head is word number length−1.
REQ-020 Throughput: with out_ready held at 1, the block SHALL sustain one word per cycle.
REQ-021 Latency: with start accepted at edge k, buf_rd_en SHALL be high in cycle k+1, out_valid SHALL be high in cycle k+3, and done SHALL be high in the cycle after the final handshake.
REQ-022 While busy=0, buf_rd_valid SHALL be ignored.
REQ-023 Simultaneous FIFO write and pop SHALL leave the occupancy unchanged, and data order SHALL be preserved.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force the following values: state IDLE, busy=0, done=0, buf_rd_en=0, buf_rd_addr=0, out_valid=0, out_last=0, out_data=0, FIFO empty, word counters cleared.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer with no done pulse. A buf_rd_valid arriving after reset SHALL be dropped.
REQ-026 The FIFO storage SHALL need no reset; only the pointers and occupancy are reset.

Verification
REQ-027 Scenario (basic): buffer preloaded with addresses 0x10..0x13 = 0xA0..0xA3; start, base=0x10, len=4, out_ready=1. Required: out words 0xA0..0xA3 on consecutive cycles, out_last with 0xA3, done one cycle later, exactly 4 buf_rd_en pulses.
REQ-028 Scenario (wrap): start, base=0xFE, len=4. Required: buf_rd_addr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-029 Scenario (backpressure): len=8 with out_ready toggling randomly, including a 10-cycle stall. Required: all 8 words in order, no duplicates or losses, at most 2 reads outstanding plus buffered, outputs stable during the stall.
REQ-030 Scenario (zero length and busy start): start with len=0. Required: done pulses in the next cycle, no buf_rd_en, out_valid stays 0. Then a second start issued during a len=4 transfer is ignored.
REQ-031 Scenario (reset mid-transfer): rst_n=0 after 3 words of a len=16 transfer. Required: all outputs at reset values the next cycle, no done pulse. A new len=2 start afterwards completes correctly.
REQ-032 Scenario (full length): len=256 with out_ready=1. Required: 256 words, out_last only on the final word, 256 cycles from first out_valid to last handshake.
